// File: rtl/jogo_memoria_generico.sv
// rtl/jogo_memoria_generico.sv - parametrised memory game core: LFSR sequence, LED playback, press checking
module jogo_memoria_generico #(
   parameter int          N_BOTOES    = 4,
   parameter int          MAX_SEQ     = 16,
   parameter int          LED_CICLOS  = 1000,
   parameter int          TIMEOUT_CIC = 5000,
   parameter logic [15:0] SEMENTE     = 16'hACE1,
   localparam int         W           = (N_BOTOES > 2) ? $clog2(N_BOTOES) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                jogar,
   input  logic [1:0]          nivel,
   input  logic [N_BOTOES-1:0] botoes,
   output logic [N_BOTOES-1:0] leds,
   output logic                pronto,
   output logic                ganhou,
   output logic                perdeu,
   output logic                timeout,
   output logic [5:0]          db_pontos,
   output logic [W-1:0]        db_memoria,
   output logic [4:0]          db_sequencia,
   output logic [3:0]          db_estado
);

   localparam int T_MAX = (LED_CICLOS > TIMEOUT_CIC) ? LED_CICLOS : TIMEOUT_CIC;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int AW    = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;

   typedef enum logic [3:0] {
      INICIAL = 4'h0,
      GERA    = 4'h1,
      MOSTRA  = 4'h2,
      APAGA   = 4'h3,
      ESPERA  = 4'h4,
      COMPARA = 4'h5,
      PROX    = 4'h6,
      NOVA    = 4'h7,
      ACERTOU = 4'hA,
      ERROU   = 4'hE,
      ESGOTOU = 4'hD
   } estado_t;

   estado_t             estado;
   logic [W-1:0]        mem [MAX_SEQ];
   logic [4:0]          addr;
   logic [4:0]          seq;
   logic [4:0]          lim;
   logic [TW-1:0]       timer;
   logic [15:0]         lfsr;
   logic                fb;
   logic [W-1:0]        lfsr_mod;
   logic [N_BOTOES-1:0] latched;
   logic                prev_any;
   logic                press;
   logic [AW-1:0]       addr_inc;
   logic [W-1:0]        mem_val;

   function automatic logic [N_BOTOES-1:0] onehot(input logic [W-1:0] idx);
      logic [N_BOTOES-1:0] one;
      one = {{(N_BOTOES-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

   // x^16 + x^14 + x^13 + x^11 + 1 feedback; the stored step is the state reduced mod N_BOTOES
   assign fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign lfsr_mod = W'(lfsr % 16'(N_BOTOES));

   // A press is the first cycle the OR of all buttons is high, so held buttons never re-trigger
   assign press    = (|botoes) & ~prev_any;
   assign addr_inc = addr[AW-1:0] + AW'(1);
   assign mem_val  = mem[addr[AW-1:0]];

   assign db_memoria   = mem_val;
   assign db_sequencia = seq;
   assign db_estado    = estado;

   // Sequence storage, filled one step per cycle while generating
   always_ff @(posedge clock) begin
      if (!reset && estado == GERA)
         mem[addr[AW-1:0]] <= lfsr_mod;
   end

   // Game FSM with registered LED and result outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         estado    <= INICIAL;
         leds      <= '0;
         pronto    <= 1'b0;
         ganhou    <= 1'b0;
         perdeu    <= 1'b0;
         timeout   <= 1'b0;
         db_pontos <= '0;
         addr      <= '0;
         seq       <= '0;
         lim       <= '0;
         timer     <= '0;
         lfsr      <= SEMENTE;
         latched   <= '0;
         prev_any  <= 1'b0;
      end else begin
         prev_any <= |botoes;
         case (estado)
            INICIAL, ACERTOU, ERROU, ESGOTOU: begin
               if (jogar) begin
                  case (nivel)
                     2'd0:    lim <= 5'(MAX_SEQ / 4 - 1);
                     2'd1:    lim <= 5'(MAX_SEQ / 2 - 1);
                     default: lim <= 5'(MAX_SEQ - 1);
                  endcase
                  db_pontos <= '0;
                  pronto    <= 1'b0;
                  ganhou    <= 1'b0;
                  perdeu    <= 1'b0;
                  timeout   <= 1'b0;
                  leds      <= '0;
                  lfsr      <= SEMENTE;
                  addr      <= '0;
                  seq       <= '0;
                  timer     <= '0;
                  estado    <= GERA;
               end
            end
            GERA: begin
               lfsr <= {lfsr[14:0], fb};
               if (addr == 5'(MAX_SEQ - 1)) begin
                  addr   <= '0;
                  seq    <= '0;
                  timer  <= '0;
                  leds   <= onehot(mem[0]);
                  estado <= MOSTRA;
               end else begin
                  addr <= addr + 5'd1;
               end
            end
            MOSTRA: begin
               if (timer == TW'(LED_CICLOS - 1)) begin
                  timer  <= '0;
                  leds   <= '0;
                  estado <= APAGA;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            APAGA: begin
               if (timer == TW'(LED_CICLOS - 1)) begin
                  timer <= '0;
                  if (addr < seq) begin
                     addr   <= addr + 5'd1;
                     leds   <= onehot(mem[addr_inc]);
                     estado <= MOSTRA;
                  end else begin
                     addr   <= '0;
                     estado <= ESPERA;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ESPERA: begin
               // a press in the last allowed cycle still counts
               if (press) begin
                  latched <= botoes;
                  leds    <= botoes;
                  timer   <= '0;
                  estado  <= COMPARA;
               end else if (timer == TW'(TIMEOUT_CIC - 1)) begin
                  timer   <= '0;
                  timeout <= 1'b1;
                  pronto  <= 1'b1;
                  estado  <= ESGOTOU;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            COMPARA: begin
               // equality with the expected one-hot pattern also rejects multiple buttons
               if (latched == onehot(mem_val)) begin
                  estado <= PROX;
               end else begin
                  leds   <= '0;
                  perdeu <= 1'b1;
                  pronto <= 1'b1;
                  estado <= ERROU;
               end
            end
            PROX: begin
               leds <= '0;
               if (addr < seq) begin
                  addr   <= addr + 5'd1;
                  estado <= ESPERA;
               end else begin
                  db_pontos <= db_pontos + 6'd1;
                  if (seq == lim) begin
                     ganhou <= 1'b1;
                     pronto <= 1'b1;
                     estado <= ACERTOU;
                  end else begin
                     estado <= NOVA;
                  end
               end
            end
            NOVA: begin
               seq    <= seq + 5'd1;
               addr   <= '0;
               timer  <= '0;
               leds   <= onehot(mem[0]);
               estado <= MOSTRA;
            end
            default: estado <= INICIAL;
         endcase
      end
   end

endmodule

// File: tb/tb_jogo_memoria_generico.sv
// tb/tb_jogo_memoria_generico.sv - self-checking bench for jogo_memoria_generico
module tb_jogo_memoria_generico;

   localparam int          N    = 4;
   localparam int          MS   = 16;
   localparam int          LC   = 4;
   localparam int          TC   = 20;
   localparam logic [15:0] SEED = 16'hACE1;

   logic         clock = 1'b0;
   logic         reset;
   logic         jogar;
   logic [1:0]   nivel;
   logic [N-1:0] botoes;
   logic [N-1:0] leds;
   logic         pronto, ganhou, perdeu, timeout;
   logic [5:0]   db_pontos;
   logic [1:0]   db_memoria;
   logic [4:0]   db_sequencia;
   logic [3:0]   db_estado;

   int checks = 0;
   int errors = 0;
   int seq_ref[MS];

   typedef struct {
      logic [1:0] nv;
      int         er;
      int         es;
      int         ek;
      logic [3:0] exp_est;
      int         exp_pts;
   } vec_t;

   vec_t vecs[6];

   jogo_memoria_generico #(
      .N_BOTOES(N), .MAX_SEQ(MS), .LED_CICLOS(LC), .TIMEOUT_CIC(TC), .SEMENTE(SEED)
   ) dut (
      .clock(clock), .reset(reset), .jogar(jogar), .nivel(nivel), .botoes(botoes),
      .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
      .db_pontos(db_pontos), .db_memoria(db_memoria), .db_sequencia(db_sequencia),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int k);
      logic [N-1:0] one;
      one = 1;
      return one << k;
   endfunction

   // Sequence as the game rules define it: successive seed states of the
   // x^16+x^14+x^13+x^11+1 shift register, each reduced mod N
   function automatic void build_ref();
      int s;
      int b;
      s = int'(SEED);
      for (int i = 0; i < MS; i++) begin
         seq_ref[i] = s % N;
         b = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
         s = ((s * 2) + b) % 65536;
      end
   endfunction

   function automatic int len_of(input logic [1:0] nv);
      if (nv == 2'd0) return MS / 4;
      if (nv == 2'd1) return MS / 2;
      return MS;
   endfunction

   task automatic start_game(input logic [1:0] nv);
      int cnt;
      nivel = nv;
      jogar = 1'b1;
      tick();
      jogar = 1'b0;
      chk("enter_gera", db_estado, 4'h1);
      chk("flags_cleared", {pronto, ganhou, perdeu, timeout}, 4'b0000);
      chk("score_cleared", db_pontos, 0);
      cnt = 0;
      while (db_estado == 4'h1 && cnt < 100) begin
         cnt++;
         tick();
      end
      chk("gera_cycles", cnt, MS);
   endtask

   task automatic playback(input int r);
      int bad;
      bad = 0;
      for (int s = 0; s <= r; s++) begin
         for (int c = 0; c < LC; c++) begin
            if (db_estado !== 4'h2 || leds !== oh(seq_ref[s])) bad++;
            tick();
         end
         for (int c = 0; c < LC; c++) begin
            if (db_estado !== 4'h3 || leds !== '0) bad++;
            tick();
         end
      end
      chk($sformatf("playback_r%0d", r), bad, 0);
      chk("espera_after_playback", db_estado, 4'h4);
      chk("round_len", db_sequencia, r);
   endtask

   task automatic run_game(input logic [1:0] nv, input int er, input int es, input int ek,
                           input logic [3:0] exp_est, input int exp_pts);
      int L;
      bit done;
      L = len_of(nv);
      done = 0;
      start_game(nv);
      for (int r = 0; r < L && !done; r++) begin
         playback(r);
         for (int s = 0; s <= r && !done; s++) begin
            chk("mem_step", db_memoria, seq_ref[s]);
            if (r == er && s == es) begin
               if (ek == 2) begin
                  for (int c = 0; c < TC - 1; c++) tick();
                  chk("timer_last_cycle", db_estado, 4'h4);
                  tick();
               end else begin
                  botoes = (ek == 0) ? oh((seq_ref[s] + 1) % N)
                                     : (oh(seq_ref[s]) | oh((seq_ref[s] + 1) % N));
                  tick();
                  chk("compara_bad", db_estado, 4'h5);
                  botoes = '0;
                  tick();
               end
               done = 1;
            end else begin
               botoes = oh(seq_ref[s]);
               tick();
               chk("compara", {db_estado, 4'(leds)}, {4'h5, 4'(oh(seq_ref[s]))});
               botoes = '0;
               tick();
               chk("prox_echo", {db_estado, 4'(leds)}, {4'h6, 4'(oh(seq_ref[s]))});
               tick();
               if (s < r) begin
                  chk("next_step", db_estado, 4'h4);
               end else if (r < L - 1) begin
                  chk("nova", db_estado, 4'h7);
                  tick();
               end
            end
         end
      end
      chk("final_state", db_estado, exp_est);
      chk("final_flags", {pronto, ganhou, perdeu, timeout},
          {1'b1, exp_est == 4'hA, exp_est == 4'hE, exp_est == 4'hD});
      chk("final_score", db_pontos, exp_pts);
      chk("final_leds", leds, 0);
   endtask

   initial begin
      logic [1:0] nv;
      int         L, ek, er, es, pts;
      logic [3:0] est;

      build_ref();
      vecs[0] = '{2'd0, -1, 0, 0, 4'hA, 4};
      vecs[1] = '{2'd0,  1, 1, 0, 4'hE, 1};
      vecs[2] = '{2'd0,  0, 0, 2, 4'hD, 0};
      vecs[3] = '{2'd0,  2, 0, 1, 4'hE, 2};
      vecs[4] = '{2'd1, -1, 0, 0, 4'hA, 8};
      vecs[5] = '{2'd1,  3, 2, 2, 4'hD, 3};

      reset  = 1'b1;
      jogar  = 1'b0;
      nivel  = 2'd0;
      botoes = '0;
      tick();
      tick();
      chk("reset_state", db_estado, 4'h0);
      chk("reset_outputs", {4'(leds), pronto, ganhou, perdeu, timeout}, 8'h00);
      chk("reset_score", db_pontos, 0);
      reset = 1'b0;
      tick();
      chk("idle_without_jogar", db_estado, 4'h0);

      // Press on the last allowed cycle beats the timeout
      start_game(2'd0);
      playback(0);
      for (int c = 0; c < TC - 1; c++) tick();
      chk("still_waiting_19", db_estado, 4'h4);
      botoes = oh(seq_ref[0]);
      tick();
      chk("late_press_state", db_estado, 4'h5);
      chk("late_press_no_timeout", timeout, 1'b0);
      botoes = '0;
      tick();
      tick();
      chk("late_press_nova", db_estado, 4'h7);
      tick();
      chk("round2_mostra", db_estado, 4'h2);
      tick();
      tick();

      // Reset in the middle of playback
      reset = 1'b1;
      tick();
      chk("reset_mid_state", db_estado, 4'h0);
      chk("reset_mid_leds", leds, 0);
      chk("reset_mid_score", db_pontos, 0);
      reset = 1'b0;

      // Table-driven games; the first replays the same seed after reset
      for (int i = 0; i < 6; i++)
         run_game(vecs[i].nv, vecs[i].er, vecs[i].es, vecs[i].ek, vecs[i].exp_est, vecs[i].exp_pts);

      // Button held from playback into ESPERA is not a press; timer keeps running
      start_game(2'd0);
      botoes = oh(seq_ref[0]);
      playback(0);
      for (int c = 0; c < TC - 1; c++) tick();
      chk("held_not_counted", db_estado, 4'h4);
      tick();
      chk("held_times_out", {db_estado, pronto, timeout}, {4'hD, 1'b1, 1'b1});
      botoes = '0;
      tick();

      // Randomised games against the rule-level outcome model
      for (int g = 0; g < 5; g++) begin
         nv = 2'($urandom_range(0, 3));
         L  = len_of(nv);
         ek = $urandom_range(0, 3);
         er = $urandom_range(0, L - 1);
         es = $urandom_range(0, er);
         if (ek == 3) begin
            er  = -1;
            est = 4'hA;
            pts = L;
         end else begin
            est = (ek == 2) ? 4'hD : 4'hE;
            pts = er;
         end
         run_game(nv, er, es, ek, est, pts);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
